// File: rtl/tdm_demux2.sv
// tdm_demux2 - two-channel time-division demultiplexer.
//
// Receives one interleaved beat stream (channel A slot marked by sof_i,
// followed by the channel B slot) and presents the recovered A/B values as a
// registered pair. A small FSM tracks slot alignment, flags framing errors and
// drives saturating pair/error counters for debug readout.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   din_i         interleaved slot data
//   din_valid_i   din_i/sof_i carry a beat this cycle (always consumed)
//   sof_i         beat is a channel-A slot (frame start)
//   a_out_o       recovered channel A, held until the next pair
//   b_out_o       recovered channel B, held until the next pair
//   out_valid_o   one-cycle pulse when a_out_o/b_out_o update
//   sel_o         1 when the next expected beat is channel B
//   sync_err_o    one-cycle pulse on a framing error
//   locked_o      1 while aligned (HAVE_A or EXPECT_A)
//   pair_cnt_o    pairs delivered, saturating
//   err_cnt_o     framing errors, saturating
//
// state       | meaning
// ------------+----------------------------------------------
// ST_IDLE     | unsynchronised, waiting for an sof beat
// ST_HAVE_A   | A slot captured in a_hold, waiting for B slot
// ST_EXPECT_A | pair delivered, waiting for the next A slot

module tdm_demux2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  input  logic             sof_i,
  output logic [WIDTH-1:0] a_out_o,
  output logic [WIDTH-1:0] b_out_o,
  output logic             out_valid_o,
  output logic             sel_o,
  output logic             sync_err_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] pair_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HAVE_A   = 2'd1,
    ST_EXPECT_A = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_hold_q, a_hold_d;
  logic [WIDTH-1:0] a_out_q, a_out_d;
  logic [WIDTH-1:0] b_out_q, b_out_d;
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             pair_inc;
  logic             err_inc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      a_hold_q    <= '0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      pair_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_hold_q    <= a_hold_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      pair_cnt_q  <= pair_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state and datapath. Cycles without a valid beat leave everything
  // untouched except the single-cycle pulses, which fall back to zero.
  always_comb begin
    state_d     = state_q;
    a_hold_d    = a_hold_q;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    pair_inc    = 1'b0;
    err_inc     = 1'b0;

    if (din_valid_i) begin
      unique case (state_q)
        ST_IDLE: begin
          // Non-sof beats while unsynchronised are dropped without an error.
          if (sof_i) begin
            a_hold_d = din_i;
            state_d  = ST_HAVE_A;
          end
        end
        ST_HAVE_A: begin
          if (!sof_i) begin
            a_out_d     = a_hold_q;
            b_out_d     = din_i;
            out_valid_d = 1'b1;
            pair_inc    = 1'b1;
            state_d     = ST_EXPECT_A;
          end else begin
            // B slot missing: the new sof beat restarts the pair.
            sync_err_d = 1'b1;
            err_inc    = 1'b1;
            a_hold_d   = din_i;
          end
        end
        ST_EXPECT_A: begin
          if (sof_i) begin
            a_hold_d = din_i;
            state_d  = ST_HAVE_A;
          end else begin
            // A slot missing: alignment is lost, resync on the next sof.
            sync_err_d = 1'b1;
            err_inc    = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pair_cnt_d = pair_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (pair_inc && (pair_cnt_q != CNT_MAX)) begin
      pair_cnt_d = pair_cnt_q + CNT_W'(1);
    end
    if (err_inc && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  assign a_out_o     = a_out_q;
  assign b_out_o     = b_out_q;
  assign out_valid_o = out_valid_q;
  assign sync_err_o  = sync_err_q;
  assign sel_o       = (state_q == ST_HAVE_A);
  assign locked_o    = (state_q != ST_IDLE);
  assign pair_cnt_o  = pair_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
